// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared Avalon-MM widths, port ids and arbiter types
package video_pkg;

    localparam int PORT_VDMA  = 0;
    localparam int PORT_AUX   = 1;
    localparam int AV_ADDR_W  = 32;
    localparam int AV_DATA_W  = 32;
    localparam int AV_BURST_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } arb_state_t;

    // One in-flight read burst: owning requester and beats still to be routed.
    typedef struct packed {
        logic                  port;
        logic [AV_BURST_W-1:0] beats;
    } burst_tag_t;

endpackage

// File: rtl/ddr_read_arbiter_if.sv
// rtl/ddr_read_arbiter_if.sv - Avalon-MM burst read channel
interface ddr_read_arbiter_if;
    import video_pkg::*;

    logic [AV_ADDR_W-1:0]  address;
    logic                  read;
    logic [AV_BURST_W-1:0] burstcount;
    logic                  waitrequest;
    logic [AV_DATA_W-1:0]  readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, burstcount,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/burst_tag_fifo.sv
// rtl/burst_tag_fifo.sv - first-word-fall-through queue of in-flight burst tags
module burst_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Fullness comes from the registered count, so a pop never frees a slot for the same cycle.
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// rtl/ddr_read_arbiter.sv - two-port DDR3 burst read arbiter with starvation guard
module ddr_read_arbiter
    import video_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 16,
    parameter int MAX_BURST       = 128
) (
    input  logic              clk_50,
    input  logic              reset_n,
    ddr_read_arbiter_if.slave  s0,
    ddr_read_arbiter_if.slave  s1,
    ddr_read_arbiter_if.master m,
    output logic              err
);

    localparam int                    TAG_W      = $bits(burst_tag_t);
    localparam logic [4:0]            STARVE_MAX = 5'(STARVE_LIMIT);
    localparam logic [AV_BURST_W-1:0] BURST_MAX  = AV_BURST_W'(MAX_BURST);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  grant_port;
    logic                  accept;
    logic                  bc_bad;
    logic                  starve_hit;
    logic                  q_empty;
    logic                  q_full;
    logic                  beat_valid;
    logic                  last_beat;
    logic [AV_BURST_W-1:0] acc_bc;
    logic [AV_BURST_W-1:0] beat_cnt;
    logic [4:0]            starve_cnt;
    logic [TAG_W-1:0]      head_bits;
    burst_tag_t            push_tag;
    burst_tag_t            head_tag;

    assign grant_port = (state == GRANT1);
    assign accept     = ((state == GRANT0 && s0.read) || (state == GRANT1 && s1.read))
                        && !m.waitrequest;
    assign acc_bc     = grant_port ? s1.burstcount : s0.burstcount;
    assign bc_bad     = (acc_bc == '0) || (acc_bc > BURST_MAX);
    assign starve_hit = (starve_cnt == STARVE_MAX);

    // Illegal lengths go to the DDR untouched but are routed as a single beat.
    assign push_tag = '{port: grant_port, beats: bc_bad ? AV_BURST_W'(1) : acc_bc};

    burst_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_tag),
        .pop       (last_beat),
        .head_data (head_bits),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign head_tag   = burst_tag_t'(head_bits);
    assign beat_valid = m.readdatavalid && !q_empty;
    assign last_beat  = beat_valid && ((beat_cnt + AV_BURST_W'(1)) == head_tag.beats);

    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign s0.readdatavalid = beat_valid && (head_tag.port == 1'(PORT_VDMA));
    assign s1.readdatavalid = beat_valid && (head_tag.port == 1'(PORT_AUX));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next     = state;
        m.read         = 1'b0;
        m.address      = '0;
        m.burstcount   = '0;
        s0.waitrequest = 1'b1;
        s1.waitrequest = 1'b1;
        case (state)
            IDLE: begin
                if (s1.read && !q_full && (!s0.read || starve_hit)) state_next = GRANT1;
                else if (s0.read && !q_full)                        state_next = GRANT0;
            end
            GRANT0: begin
                m.read         = s0.read;
                m.address      = s0.address;
                m.burstcount   = s0.burstcount;
                s0.waitrequest = m.waitrequest;
                if (!s0.read || !m.waitrequest) state_next = IDLE;
            end
            GRANT1: begin
                m.read         = s1.read;
                m.address      = s1.address;
                m.burstcount   = s1.burstcount;
                s1.waitrequest = m.waitrequest;
                if (!s1.read || !m.waitrequest) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)        beat_cnt <= '0;
        else if (last_beat)  beat_cnt <= '0;
        else if (beat_valid) beat_cnt <= beat_cnt + AV_BURST_W'(1);
    end

    // Counts port-0 wins only while port 1 is actually waiting.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)                                     starve_cnt <= '0;
        else if ((accept && grant_port) || !s1.read)      starve_cnt <= '0;
        else if (accept && !grant_port && starve_cnt != 5'h1f) starve_cnt <= starve_cnt + 5'd1;
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)                                              err <= 1'b0;
        else if ((m.readdatavalid && q_empty) || (accept && bc_bad)) err <= 1'b1;
    end

endmodule

// File: doc/ddr_read_arbiter.md
DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, is the depth of the in-flight burst tracking queue.
REQ-002 Parameter STARVE_LIMIT, default 16, is the number of consecutive port-0 grants after which pending port 1 wins.
REQ-003 Parameter MAX_BURST, default 128, is the largest legal burstcount.
REQ-004 clk_50  input  1  sole clock; all logic on clk_50.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sN_address (N=0,1)  input  32  requester N read address; port 0 = video DMA, port 1 = auxiliary reader.
REQ-007 sN_read  input  1  requester N read request, held until accepted.
REQ-008 sN_burstcount  input  8  requester N burst length.
REQ-009 sN_waitrequest  output  1  stall to requester N.
REQ-010 sN_readdata  output  32  return data, broadcast from m_readdata.
REQ-011 sN_readdatavalid  output  1  return beat valid, routed to owning requester.
REQ-012 m_address / m_read / m_burstcount  output  32/1/8  DDR3 Avalon-MM read command.
REQ-013 m_waitrequest / m_readdata / m_readdatavalid  input  1/32/1  DDR3 response.
REQ-014 err  output  1  sticky protocol error flag.

Function
REQ-015 FSM states IDLE, GRANT0, GRANT1; the grant decision is registered, giving 1-cycle arbitration latency from sN_read to m_read.
REQ-016 IDLE -> GRANT0 if s0_read and queue not full and not (starve_cnt = STARVE_LIMIT and s1_read).
REQ-017 IDLE -> GRANT1 if s1_read, queue not full, and (not s0_read or starve_cnt = STARVE_LIMIT).
REQ-018 In GRANTn: m_address/m_read/m_burstcount follow port n combinationally; sn_waitrequest = m_waitrequest; other port waitrequest = 1.
REQ-019 GRANTn -> IDLE on accept (m_read and not m_waitrequest); one idle cycle between commands is required.
REQ-020 GRANTn -> IDLE without issue if sn_read deasserts before accept; nothing is queued.
REQ-021 In IDLE: m_read = 0; both sN_waitrequest = 1.
REQ-022 On accept, push {port, burstcount} into the tracking queue.
REQ-023 Each m_readdatavalid asserts readdatavalid of the queue-head port only and decrements the head beat counter; the last beat pops the head.
REQ-024 Push and pop in the same cycle are both honoured; occupancy is unchanged.
REQ-025 Queue full (MAX_OUTSTANDING entries) blocks new grants; fullness is evaluated on registered occupancy, so a same-cycle pop does not unblock until the next cycle.
REQ-026 starve_cnt (5 bits, saturating) increments on each port-0 accept while s1_read = 1; it clears on a port-1 accept or when s1_read = 0.
REQ-027 err sets on m_readdatavalid with the queue empty, with the beat dropped (no sN_readdatavalid); err also sets on accept with burstcount = 0 or > MAX_BURST, which is forwarded unchanged and tracked as 1 beat.
REQ-028 err clears only on reset.

Reset
REQ-029 Reset values: state IDLE; queue empty; starve_cnt 0; err 0; m_read 0; m_address 0; m_burstcount 0; sN_waitrequest 1; sN_readdatavalid 0.
REQ-030 Reset mid-burst discards all queue entries; beats returning after reset release set err.

Structure
REQ-031 Shared package video_pkg holds PORT_VDMA = 0, PORT_AUX = 1, AV_ADDR_W = 32, AV_DATA_W = 32, AV_BURST_W = 8.
REQ-032 Tracking queue is a sub-module burst_tag_fifo (synchronous, single clock, first-word-fall-through, width 1+AV_BURST_W).

Verification
REQ-033 s0 burst 64 at 0x1000_0000, no waitrequest -> m_read 1 cycle after s0_read; 64 beats reach s0 only, err = 0.
REQ-034 s0 and s1 both requesting continuously -> 16 port-0 grants, then 1 port-1 grant, and the pattern repeats.
REQ-035 4 accepted bursts with no returns, then a 5th request -> sN_waitrequest stays 1; after the first burst's last beat, the grant follows 1 cycle later.
REQ-036 Interleaved s0 (8 beats) then s1 (4 beats) -> beats 1-8 go to s0, 9-12 go to s1, in order.
REQ-037 m_readdatavalid with the queue empty -> err = 1, no sN_readdatavalid; err persists until reset_n pulse.
REQ-038 reset_n asserted mid-GRANT1 with m_waitrequest = 1 -> all outputs at reset values within the same cycle.
